// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_defs: shared definitions for the EX-stage multi-cycle divider.
//   - DATA_W_DEF : default operand/result width (also the iteration count)
//   - state_t    : divider FSM encoding (IDLE, CALC, DONE)
//   - cnt_width  : width of the iteration counter for a given data width
// -----------------------------------------------------------------------------
package div_defs;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must reach DATA_W-1, so clog2(DATA_W) bits suffice.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// -----------------------------------------------------------------------------
// div_unit_if: E-stage <-> divider connection.
//   master (E-stage / hazard side): drives start, is_signed, a, b, flush;
//                                   receives stall_req, result_valid,
//                                   quotient, remainder.
//   slave  (div_unit):              the mirror image.
// -----------------------------------------------------------------------------
interface div_unit_if
    import div_defs::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              start;
    logic              is_signed;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              flush;
    logic              stall_req;
    logic              result_valid;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;

    modport master (
        output start, is_signed, a, b, flush,
        input  stall_req, result_valid, quotient, remainder
    );

    modport slave (
        input  start, is_signed, a, b, flush,
        output stall_req, result_valid, quotient, remainder
    );

endinterface

// File: rtl/div_unit_abs_sign.sv
// -----------------------------------------------------------------------------
// div_abs_sign: combinational magnitude / sign extraction.
//   value     in  DATA_W  operand
//   is_signed in  1       treat value as two's complement
//   negate    in  1       force two's-complement negation (sign fixup use)
//   result    out DATA_W  |value| when signed and negative, -value when
//                         negate, otherwise value unchanged
//   sign      out 1       sign bit of value when is_signed, else 0
// -----------------------------------------------------------------------------
module div_abs_sign
    import div_defs::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] value,
    input  logic              is_signed,
    input  logic              negate,
    output logic [DATA_W-1:0] result,
    output logic              sign
);

    assign sign   = is_signed & value[DATA_W-1];
    // The most negative value maps onto itself, which read as unsigned is
    // exactly its magnitude, so no special case is needed.
    assign result = (sign | negate) ? (~value + 1'b1) : value;

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU in EX.
//   clk  in  pipeline clock
//   rst  in  synchronous reset, active-high
//   dif  div_unit_if.slave:
//     start, is_signed, a, b, flush  (inputs from the E stage)
//     stall_req                      (combinational, to the hazard unit)
//     result_valid, quotient (LO), remainder (HI)
// A division seen in IDLE at cycle T stalls the pipe for T..T+32 and
// presents the result for one cycle at T+33 (DONE), when E is released.
// -----------------------------------------------------------------------------
module div_unit
    import div_defs::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave dif
);

    localparam int             CNT_W = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  counter;
    logic              stall;

    // Iteration working set, loaded from the operands in IDLE.
    logic [DATA_W-1:0] part_rem, part_quo, divisor_mag, dividend_raw;
    logic              sign_q, sign_r, div0;

    logic              result_valid_q;
    logic [DATA_W-1:0] quotient_q, remainder_q;

    logic [DATA_W-1:0] a_mag, b_mag;
    logic              a_sign, b_sign;

    logic [DATA_W:0]   shifted, trial;
    logic [DATA_W-1:0] rem_step, quo_step;
    logic [DATA_W-1:0] q_fixed, r_fixed;
    logic              unused_q_sign, unused_r_sign;

    div_abs_sign #(.DATA_W(DATA_W)) u_abs_a (
        .value(dif.a), .is_signed(dif.is_signed), .negate(1'b0),
        .result(a_mag), .sign(a_sign)
    );

    div_abs_sign #(.DATA_W(DATA_W)) u_abs_b (
        .value(dif.b), .is_signed(dif.is_signed), .negate(1'b0),
        .result(b_mag), .sign(b_sign)
    );

    // One restoring step: bring in the next dividend bit, try the subtract,
    // keep it (and set the quotient bit) only if it did not borrow.
    always_comb begin
        shifted  = {part_rem, part_quo[DATA_W-1]};
        trial    = shifted - {1'b0, divisor_mag};
        quo_step = {part_quo[DATA_W-2:0], ~trial[DATA_W]};
        rem_step = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
    end

    // Sign fixups on the final step's result; suppressed for divide by zero.
    div_abs_sign #(.DATA_W(DATA_W)) u_fix_q (
        .value(quo_step), .is_signed(1'b0), .negate(sign_q & ~div0),
        .result(q_fixed), .sign(unused_q_sign)
    );

    div_abs_sign #(.DATA_W(DATA_W)) u_fix_r (
        .value(rem_step), .is_signed(1'b0), .negate(sign_r & ~div0),
        .result(r_fixed), .sign(unused_r_sign)
    );

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        if (dif.flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (dif.start) begin
                        state_nxt = CALC;
                        stall     = 1'b1;
                    end
                end
                CALC: begin
                    stall = 1'b1;
                    if (counter == LAST) state_nxt = DONE;
                end
                // start is still high here; returning unconditionally keeps
                // the same instruction from retriggering.
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: the working registers are deliberately left out of reset; they
    // are always reloaded in IDLE before CALC ever reads them.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter        <= '0;
            result_valid_q <= 1'b0;
            quotient_q     <= '0;
            remainder_q    <= '0;
        end else begin
            result_valid_q <= 1'b0;
            if (dif.flush) begin
                counter <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (dif.start) begin
                            part_rem     <= '0;
                            part_quo     <= a_mag;
                            divisor_mag  <= b_mag;
                            dividend_raw <= dif.a;
                            sign_q       <= a_sign ^ b_sign;
                            sign_r       <= a_sign;
                            div0         <= (dif.b == '0);
                            counter      <= '0;
                        end
                    end
                    CALC: begin
                        part_rem <= rem_step;
                        part_quo <= quo_step;
                        if (counter == LAST) begin
                            counter        <= '0;
                            result_valid_q <= 1'b1;
                            quotient_q     <= div0 ? '1 : q_fixed;
                            remainder_q    <= div0 ? dividend_raw : r_fixed;
                        end else begin
                            counter <= counter + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dif.stall_req    = stall;
    assign dif.result_valid = result_valid_q;
    assign dif.quotient     = quotient_q;
    assign dif.remainder    = remainder_q;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit: self-checking bench for div_unit (DATA_W = 32).
// A cycle-level reference (operation age + arithmetic result) is compared to
// the DUT every cycle; directed vectors carry hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_div_unit;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    div_unit_if #(.DATA_W(32)) dif ();

    div_unit #(.DATA_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .dif(dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference arithmetic: {quotient, remainder}.
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] av,
                                            input logic [31:0] bv);
        longint sa, sb, q, r;
        if (bv == 32'd0) return {32'hFFFF_FFFF, av};
        if (s) begin
            sa = longint'($signed(av));
            sb = longint'($signed(bv));
        end else begin
            sa = longint'({32'd0, av});
            sb = longint'({32'd0, bv});
        end
        q = sa / sb;
        r = sa % sb;
        return {q[31:0], r[31:0]};
    endfunction

    // Timing reference: m_age 0 = idle, k = cycle T+k of an operation.
    int          m_age = 0;
    logic [31:0] m_q   = '0;
    logic [31:0] m_r   = '0;

    always @(posedge clk) begin
        if (rst || dif.flush) begin
            m_age <= 0;
        end else if (m_age == 0) begin
            if (dif.start) begin
                m_age      <= 1;
                {m_q, m_r} <= ref_div(dif.is_signed, dif.a, dif.b);
            end
        end else if (m_age == 33) begin
            m_age <= 0;
        end else begin
            m_age <= m_age + 1;
        end
    end

    always @(negedge clk) begin : compare
        bit exp_stall;
        if (!rst) begin
            exp_stall = !dif.flush &&
                        ((m_age == 0 && dif.start) || (m_age >= 1 && m_age <= 32));
            check("mon_stall_req", 64'(dif.stall_req), 64'(exp_stall));
            check("mon_result_valid", 64'(dif.result_valid), 64'(m_age == 33));
            if (m_age == 33) begin
                check("mon_quotient", 64'(dif.quotient), 64'(m_q));
                check("mon_remainder", 64'(dif.remainder), 64'(m_r));
            end
        end
    end

    // Called at posedge+#1. Issues one division and waits for its strobe.
    task automatic run_div(input string name, input bit s,
                           input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] exp_q, input logic [31:0] exp_r,
                           input bit keep_start);
        int cyc;
        int stalls;
        dif.start     = 1'b1;
        dif.is_signed = s;
        dif.a         = av;
        dif.b         = bv;
        cyc    = 0;
        stalls = 0;
        @(negedge clk);
        while (!dif.result_valid && cyc < 100) begin
            if (dif.stall_req) stalls++;
            cyc++;
            @(negedge clk);
        end
        check({name, "_latency"}, 64'(cyc), 64'd33);
        check({name, "_stall_cycles"}, 64'(stalls), 64'd33);
        check({name, "_stall_at_done"}, 64'(dif.stall_req), 64'd0);
        check({name, "_quotient"}, 64'(dif.quotient), 64'(exp_q));
        check({name, "_remainder"}, 64'(dif.remainder), 64'(exp_r));
        @(posedge clk);
        #1;
        if (!keep_start) dif.start = 1'b0;
    endtask

    initial begin
        int seen;
        rst           = 1'b1;
        dif.start     = 1'b0;
        dif.is_signed = 1'b0;
        dif.a         = '0;
        dif.b         = '0;
        dif.flush     = 1'b0;

        // Pin the reference arithmetic against hand-computed values.
        check("model_divu", ref_div(1'b0, 32'd100, 32'd7), {32'd14, 32'd2});
        check("model_div_neg", ref_div(1'b1, 32'hFFFF_FFF9, 32'd2),
              {32'hFFFF_FFFD, 32'hFFFF_FFFF});
        check("model_ovf", ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF),
              {32'h8000_0000, 32'd0});
        check("model_div0", ref_div(1'b1, 32'hFFFF_FFF9, 32'd0),
              {32'hFFFF_FFFF, 32'hFFFF_FFF9});

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_stall_req", 64'(dif.stall_req), 64'd0);
        check("reset_result_valid", 64'(dif.result_valid), 64'd0);
        check("reset_quotient", 64'(dif.quotient), 64'd0);
        check("reset_remainder", 64'(dif.remainder), 64'd0);
        @(posedge clk);
        #1;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
                32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE,
                32'hFFFF_FFFD, 32'd1, 1'b0);
        run_div("div0", 1'b1, 32'hFFFF_FFF9, 32'd0,
                32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0);

        // Flush at T+10 of DIVU 1000/3.
        dif.start     = 1'b1;
        dif.is_signed = 1'b0;
        dif.a         = 32'd1000;
        dif.b         = 32'd3;
        repeat (10) @(posedge clk);
        #1 dif.flush = 1'b1;
        @(negedge clk);
        check("flush_stall_same_cycle", 64'(dif.stall_req), 64'd0);
        @(posedge clk);
        #1;
        dif.flush = 1'b0;
        dif.start = 1'b0;
        @(negedge clk);
        check("flush_idle_stall", 64'(dif.stall_req), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (dif.result_valid) seen++;
            @(negedge clk);
        end
        check("flush_no_result", 64'(seen), 64'd0);
        @(posedge clk);
        #1;
        run_div("divu_9_4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0);

        // Overflow with start held through DONE, then DIVU 10/3 back-to-back.
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                32'h8000_0000, 32'd0, 1'b1);
        run_div("divu_10_3_b2b", 1'b0, 32'd10, 32'd3, 32'd3, 32'd1, 1'b0);

        // Results hold after the strobe.
        repeat (3) @(negedge clk);
        check("hold_quotient", 64'(dif.quotient), 64'd3);
        check("hold_remainder", 64'(dif.remainder), 64'd1);

        // Reset mid-CALC clears the result registers and aborts.
        @(posedge clk);
        #1;
        dif.start = 1'b1;
        dif.a     = 32'd50;
        dif.b     = 32'd5;
        repeat (6) @(posedge clk);
        #1;
        rst       = 1'b1;
        dif.start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_stall", 64'(dif.stall_req), 64'd0);
        check("rst_mid_valid", 64'(dif.result_valid), 64'd0);
        check("rst_mid_quotient", 64'(dif.quotient), 64'd0);
        check("rst_mid_remainder", 64'(dif.remainder), 64'd0);
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
